bcd_stopwatch_ctrl: RTL

Stopwatch controller that sequences a chain of synchronous BCD digit counters from three push-button inputs. It implements start/stop, lap-freeze and clear. Counting is paced by an internal clock-enable prescaler. It sits between the debounced button inputs and the 7-segment display decoders, and supplies packed BCD digits plus status flags.

---
 rtl/bcd_stopwatch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_ctrl
//  Description : Stopwatch controller. Detects button edges, sequences
//                IDLE/RUN/PAUSE/LAP_RUN and drives a synchronous BCD counter
//                chain paced by a clock-enable prescaler. Provides packed BCD
//                display digits, lap freeze and a sticky wrap flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  start_stop_btn,
  input  logic                  lap_btn,
  input  logic                  clear_btn,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  lap_hold,
  output logic                  overflow
);

  // Prescaler width; a divide-by-1 still needs a one-bit register.
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    LAP_RUN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  start_q;
  logic                  lap_q;
  logic                  clear_q;
  logic                  start_edge;
  logic                  lap_edge;
  logic                  clear_edge;
  logic                  lap_latch;
  logic                  clear_all;
  logic                  counting;
  logic                  tick;
  logic [PW-1:0]         presc;
  logic [4*DIGITS-1:0]   count;
  logic [4*DIGITS-1:0]   count_inc;
  logic [4*DIGITS-1:0]   lap_reg;
  logic [DIGITS:0]       carry;

  // One-cycle-delayed copies of the buttons give exactly one edge per press.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      start_q <= 1'b0;
      lap_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= start_stop_btn;
      lap_q   <= lap_btn;
      clear_q <= clear_btn;
    end
  end

  assign start_edge = start_stop_btn & ~start_q;
  assign lap_edge   = lap_btn        & ~lap_q;
  assign clear_edge = clear_btn      & ~clear_q;

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: within each state only legal edges are tested, in
  // clear > start > lap order, so the highest legal edge wins.
  always_comb begin
    state_nxt = state;
    lap_latch = 1'b0;
    clear_all = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_nxt = RUN;
      end
      RUN: begin
        if (start_edge) begin
          state_nxt = PAUSE;
        end else if (lap_edge) begin
          state_nxt = LAP_RUN;
          lap_latch = 1'b1;
        end
      end
      LAP_RUN: begin
        if (start_edge)    state_nxt = PAUSE;
        else if (lap_edge) state_nxt = RUN;
      end
      PAUSE: begin
        if (clear_edge) begin
          state_nxt = IDLE;
          clear_all = 1'b1;
        end else if (start_edge) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counting is enabled by the current state, so a tick on a command edge
  // still lands.
  assign counting = (state == RUN) || (state == LAP_RUN);
  assign tick     = counting && (presc == PRESC_MAX);

  // Prescaler holds in PAUSE so resumed runs keep their partial period.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      presc <= '0;
    end else if (clear_all) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else if (counting) begin
      presc <= presc + PW'(1);
    end
  end

  // Synchronous BCD carry chain: all digits update on the same edge.
  assign carry[0] = tick;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] d;
    assign d              = count[4*gi +: 4];
    assign carry[gi+1]    = carry[gi] & (d == 4'd9);
    assign count_inc[4*gi +: 4] = carry[gi] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
  end

  // Count and sticky overflow; a carry out of the top digit is the wrap.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_all) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_inc;
      if (carry[DIGITS]) overflow <= 1'b1;
    end
  end

  // Lap snapshot captures the pre-increment count.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lap_reg <= '0;
    end else if (lap_latch) begin
      lap_reg <= count;
    end
  end

  assign digits   = (state == LAP_RUN) ? lap_reg : count;
  assign running  = counting;
  assign lap_hold = (state == LAP_RUN);

endmodule
`default_nettype wire
